// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants shared by the frame controller and its sub-blocks.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_BOTTOM  = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOP     = 33;

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [CNT_W-1:0] pos_t;

endpackage

// File: rtl/vga_cfg_shadow.sv
// Config shadow: one pending slot filled by valid/ready handshake, promoted to cfg_active on apply.
module vga_cfg_shadow (
  input  logic       clk,
  input  logic       reset,
  input  logic       apply,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  output logic [7:0] cfg_active
);

  logic [7:0] pending_q, pending_d;
  logic [7:0] active_q, active_d;
  logic       ready_q, ready_d;

  // A pending value is only promoted if it was already held before this edge;
  // an offer accepted on the apply edge itself waits for the next vblank.
  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    ready_d   = ready_q;
    if (apply && !ready_q) begin
      active_d = pending_q;
      ready_d  = 1'b1;
    end
    if (cfg_valid && ready_q) begin
      pending_d = cfg_data;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 8'h00;
      active_q  <= 8'h00;
      ready_q   <= 1'b1;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      ready_q   <= ready_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign cfg_active = active_q;

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA frame controller: pixel/line counters, sync and blanking decode, frame counter, config shadow.
module vga_frame_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_DISP = H_DISPLAY,
  parameter int H_FP   = H_FRONT,
  parameter int H_SW   = H_SYNC,
  parameter int H_BP   = H_BACK,
  parameter int V_DISP = V_DISPLAY,
  parameter int V_FP   = V_BOTTOM,
  parameter int V_SW   = V_SYNC,
  parameter int V_BP   = V_TOP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ready,
  output logic [7:0]       cfg_active,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam pos_t H_LAST   = pos_t'(H_DISP + H_FP + H_SW + H_BP - 1);
  localparam pos_t V_LAST   = pos_t'(V_DISP + V_FP + V_SW + V_BP - 1);
  localparam pos_t H_VIS    = pos_t'(H_DISP);
  localparam pos_t V_VIS    = pos_t'(V_DISP);
  localparam pos_t V_PRE_VB = pos_t'(V_DISP - 1);
  localparam pos_t HS_FIRST = pos_t'(H_DISP + H_FP);
  localparam pos_t HS_LAST  = pos_t'(H_DISP + H_FP + H_SW - 1);
  localparam pos_t VS_FIRST = pos_t'(V_DISP + V_FP);
  localparam pos_t VS_LAST  = pos_t'(V_DISP + V_FP + V_SW - 1);

  pos_t       hpos_q, hpos_d;
  pos_t       vpos_q, vpos_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       h_wrap, v_wrap, apply;

  assign h_wrap = (hpos_q == H_LAST);
  assign v_wrap = (vpos_q == V_LAST);
  // Apply edge: the counters are about to move to (0, V_DISP), the start of vblank.
  assign apply  = h_wrap && (vpos_q == V_PRE_VB);

  always_comb begin
    hpos_d      = hpos_q + pos_t'(1);
    vpos_d      = vpos_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      hpos_d = '0;
      vpos_d = v_wrap ? '0 : vpos_q + pos_t'(1);
      if (v_wrap && !pause) frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q      <= '0;
      vpos_q      <= '0;
      frame_cnt_q <= 8'h00;
    end else begin
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  vga_cfg_shadow u_cfg_shadow (
    .clk        (clk),
    .reset      (reset),
    .apply      (apply),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .cfg_active (cfg_active)
  );

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_cnt   = frame_cnt_q;
  assign hsync       = !((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST));
  assign vsync       = !((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST));
  assign display_on  = (hpos_q < H_VIS) && (vpos_q < V_VIS);
  assign line_start  = (hpos_q == '0);
  assign frame_start = (hpos_q == '0) && (vpos_q == '0);

endmodule
